rc4_keyspace_scheduler: RTL
===========================

RC4_KEYSPACE_SCHEDULER -- requirements
Module: rc4_keyspace_scheduler

Interface
REQ-001 Parameter KEY_W, default 22, width of the key index.
REQ-002 Parameter NUM_CORES, default 4, number of decrypt cores served (1..32).
REQ-003 The block SHALL have clock clk; reset rst, asynchronous, active-high.
REQ-004 start  in  1  one-cycle pulse, begin search over [key_lo, key_hi]; sampled only in IDLE.
REQ-005 abort  in  1  stop the search and return to IDLE; honoured in any state.
REQ-006 key_lo  in  KEY_W  first key of range; sampled on accepted start.
REQ-007 key_hi  in  KEY_W  last key of range, inclusive; sampled on accepted start.
REQ-008 core_done  in  NUM_CORES  per-core level, decrypt finished; held until that core's core_reset.
REQ-009 core_valid  in  NUM_CORES  per-core plaintext valid; qualified by core_done.
REQ-010 core_reset  out  NUM_CORES  per-core one-cycle restart pulse with a new key.
REQ-011 core_key  out  NUM_CORES*KEY_W  key for core i in bits [i*KEY_W +: KEY_W]; stable while the core runs.
REQ-012 busy  out  1  high in LOAD and RUN.
REQ-013 solved  out  1  sticky; a core reported a valid key.
REQ-014 exhausted  out  1  sticky; range finished, no valid key.
REQ-015 solved_key  out  KEY_W  winning key; 0 unless solved.
REQ-016 keys_tried  out  KEY_W+1  count of keys completed invalid in this search.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, RUN, SOLVED, EXHAUSTED.
REQ-018 IDLE: start -> LOAD; next_key <= key_lo; hi <= key_hi; keys_tried, solved, exhausted, solved_key cleared; the active mask is cleared.
REQ-019 LOAD (one cycle): core i is activated with core_key[i] = next_key+i and a core_reset[i] pulse only if next_key+i <= hi; next_key <= next_key + (number of cores activated); -> RUN.
REQ-020 next_key and all range compares SHALL use KEY_W+1 bits, so key_hi = all-ones ends the search and never wraps to 0.
REQ-021 If key_lo > key_hi at start, LOAD SHALL activate no core and the FSM SHALL go to EXHAUSTED on the next cycle.
REQ-022 RUN: an active core is eligible when core_done is high and the core is not in its 2-cycle blanking window (the cycle of its core_reset pulse and the following cycle).
REQ-023 Eligible cores with core_valid high: the lowest-index core wins; solved_key <= its core_key; solved <= 1 the next cycle; -> SOLVED; no further core_reset is issued.
REQ-024 Otherwise, exactly one eligible invalid core is serviced per cycle, lowest index first; others wait.
REQ-025 Serviced core: keys_tried++. If next_key <= hi: core_key <= next_key, core_reset pulse next cycle, next_key++. Else the core is retired (inactive).
REQ-026 When no core is active in RUN, the FSM SHALL go to EXHAUSTED and set exhausted the next cycle.
REQ-027 Valid and invalid eligible cores in the same cycle: valid takes priority and the invalid result is not counted.
REQ-028 SOLVED and EXHAUSTED are held until start (re-run via LOAD) or abort (-> IDLE).
REQ-029 abort: -> IDLE next cycle; the active mask is cleared; no core_reset issued; solved, exhausted, solved_key, keys_tried are held; abort wins over simultaneous start.
REQ-030 core_done and core_valid of inactive cores SHALL be ignored.

Reset
REQ-031 rst SHALL force IDLE; core_reset=0, core_key=0, busy=0, solved=0, exhausted=0, solved_key=0, keys_tried=0, active mask=0, next_key=0.
REQ-032 rst mid-search SHALL take effect immediately (asynchronously), without completing pending dispatches.

Verification
REQ-033 NUM_CORES=4, lo=0, hi=9, valid only on key 6 -> cores get keys 0..3, core_reset=4'b1111 after LOAD; solved=1, solved_key=6, keys_tried counts every invalid key completed before the key-6 result, no key >9 dispatched.
REQ-034 lo=0, hi=5, no valid -> keys 4,5 dispatched once each, then exhausted=1, keys_tried=6, solved=0.
REQ-035 hi=all-ones (KEY_W=22), lo=0x3FFFFE, no valid -> cores 0,1 active only, exhausted after 2 results, no wrap to key 0.
REQ-036 Cores 1 and 3 done the same cycle, both valid (keys 5, 7) -> solved_key=5.
REQ-037 Cores 0 and 2 done invalid the same cycle -> core 0 reloaded that cycle, core 2 the next; keys sequential.
REQ-038 abort in RUN, then rst mid-LOAD -> IDLE, all outputs at reset values, no core_reset pulse after rst.

Source files
------------

// File: rtl/rc4_keyspace_scheduler.sv
// RC4 key-space search scheduler.
// Hands out consecutive keys from [key_lo, key_hi] to a bank of decrypt cores.
// Each finished core is either declared the winner or reloaded with the next key.
// The search ends when a core reports valid plaintext or the range runs out.
module rc4_keyspace_scheduler #(
   parameter int KEY_W     = 22,
   parameter int NUM_CORES = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         abort,
   input  logic [KEY_W-1:0]             key_lo,
   input  logic [KEY_W-1:0]             key_hi,
   input  logic [NUM_CORES-1:0]         core_done,
   input  logic [NUM_CORES-1:0]         core_valid,
   output logic [NUM_CORES-1:0]         core_reset,
   output logic [NUM_CORES*KEY_W-1:0]   core_key,
   output logic                         busy,
   output logic                         solved,
   output logic                         exhausted,
   output logic [KEY_W-1:0]             solved_key,
   output logic [KEY_W:0]               keys_tried
);

   localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam logic [KEY_W:0] ONE = {{KEY_W{1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_SOLVED,
      ST_EXHAUSTED
   } state_t;

   state_t                 state_reg, state_next;
   // Keys and the range limit carry one extra bit so key_hi = all-ones cannot wrap.
   logic [KEY_W:0]         next_key_reg, next_key_next;
   logic [KEY_W:0]         hi_reg, hi_next;
   logic [NUM_CORES-1:0]   active_reg, active_next;
   logic [NUM_CORES-1:0]   core_reset_reg, core_reset_next;
   logic [NUM_CORES-1:0]   core_reset_d_reg;
   logic [KEY_W-1:0]       core_key_reg  [NUM_CORES];
   logic [KEY_W-1:0]       core_key_next [NUM_CORES];
   logic                   solved_reg, solved_next;
   logic                   exhausted_reg, exhausted_next;
   logic [KEY_W-1:0]       solved_key_reg, solved_key_next;
   logic [KEY_W:0]         keys_tried_reg, keys_tried_next;

   logic [KEY_W:0]         load_key [NUM_CORES];
   logic [NUM_CORES-1:0]   load_ok;
   logic [NUM_CORES-1:0]   eligible;
   logic [NUM_CORES-1:0]   win_vec;
   logic [NUM_CORES-1:0]   lose_vec;
   logic [KEY_W:0]         load_count;
   logic                   win_any, lose_any;
   logic [IW-1:0]          win_idx, lose_idx;

   // Per-core key offsets for the initial load, result eligibility and key outputs.
   // A core is blanked during its restart pulse and the cycle after, so a stale
   // done level from the previous key is never mistaken for a new result.
   for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
      assign load_key[gi] = next_key_reg + (KEY_W+1)'(gi);
      assign load_ok[gi]  = (load_key[gi] <= hi_reg);
      assign eligible[gi] = active_reg[gi] & core_done[gi]
                          & ~core_reset_reg[gi] & ~core_reset_d_reg[gi];
      assign win_vec[gi]  = eligible[gi] & core_valid[gi];
      assign lose_vec[gi] = eligible[gi] & ~core_valid[gi];
      assign core_key[gi*KEY_W +: KEY_W] = core_key_reg[gi];
   end

   // Lowest-index priority encoders and the count of cores filled by the load.
   always_comb begin
      win_any    = 1'b0;
      win_idx    = '0;
      lose_any   = 1'b0;
      lose_idx   = '0;
      load_count = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (win_vec[i]) begin
            win_any = 1'b1;
            win_idx = IW'(i);
         end
         if (lose_vec[i]) begin
            lose_any = 1'b1;
            lose_idx = IW'(i);
         end
      end
      for (int i = 0; i < NUM_CORES; i++) begin
         if (load_ok[i]) begin
            load_count = load_count + ONE;
         end
      end
   end

   // Next-state and datapath updates for the search FSM.
   always_comb begin
      state_next      = state_reg;
      next_key_next   = next_key_reg;
      hi_next         = hi_reg;
      active_next     = active_reg;
      core_reset_next = '0;
      core_key_next   = core_key_reg;
      solved_next     = solved_reg;
      exhausted_next  = exhausted_reg;
      solved_key_next = solved_key_reg;
      keys_tried_next = keys_tried_reg;

      if (abort) begin
         // Results are kept for inspection; the cores are simply abandoned.
         state_next  = ST_IDLE;
         active_next = '0;
      end else begin
         case (state_reg)
            ST_IDLE, ST_SOLVED, ST_EXHAUSTED: begin
               if (start) begin
                  state_next      = ST_LOAD;
                  next_key_next   = {1'b0, key_lo};
                  hi_next         = {1'b0, key_hi};
                  active_next     = '0;
                  solved_next     = 1'b0;
                  exhausted_next  = 1'b0;
                  solved_key_next = '0;
                  keys_tried_next = '0;
               end
            end
            ST_LOAD: begin
               for (int i = 0; i < NUM_CORES; i++) begin
                  if (load_ok[i]) begin
                     core_key_next[i]   = load_key[i][KEY_W-1:0];
                     core_reset_next[i] = 1'b1;
                     active_next[i]     = 1'b1;
                  end
               end
               next_key_next = next_key_reg + load_count;
               // An empty range (key_lo > key_hi) has nothing to run.
               if (load_ok[0]) begin
                  state_next = ST_RUN;
               end else begin
                  state_next     = ST_EXHAUSTED;
                  exhausted_next = 1'b1;
               end
            end
            ST_RUN: begin
               if (active_reg == '0) begin
                  state_next     = ST_EXHAUSTED;
                  exhausted_next = 1'b1;
               end else if (win_any) begin
                  // A valid result beats any invalid result in the same cycle.
                  state_next      = ST_SOLVED;
                  solved_next     = 1'b1;
                  solved_key_next = core_key_reg[win_idx];
                  active_next     = '0;
               end else if (lose_any) begin
                  keys_tried_next = keys_tried_reg + ONE;
                  if (next_key_reg <= hi_reg) begin
                     core_key_next[lose_idx]   = next_key_reg[KEY_W-1:0];
                     core_reset_next[lose_idx] = 1'b1;
                     next_key_next             = next_key_reg + ONE;
                  end else begin
                     active_next[lose_idx] = 1'b0;
                  end
               end
            end
            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end
   end

   // State and datapath registers; reset acts immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg        <= ST_IDLE;
         next_key_reg     <= '0;
         hi_reg           <= '0;
         active_reg       <= '0;
         core_reset_reg   <= '0;
         core_reset_d_reg <= '0;
         for (int i = 0; i < NUM_CORES; i++) begin
            core_key_reg[i] <= '0;
         end
         solved_reg       <= 1'b0;
         exhausted_reg    <= 1'b0;
         solved_key_reg   <= '0;
         keys_tried_reg   <= '0;
      end else begin
         state_reg        <= state_next;
         next_key_reg     <= next_key_next;
         hi_reg           <= hi_next;
         active_reg       <= active_next;
         core_reset_reg   <= core_reset_next;
         core_reset_d_reg <= core_reset_reg;
         for (int i = 0; i < NUM_CORES; i++) begin
            core_key_reg[i] <= core_key_next[i];
         end
         solved_reg       <= solved_next;
         exhausted_reg    <= exhausted_next;
         solved_key_reg   <= solved_key_next;
         keys_tried_reg   <= keys_tried_next;
      end
   end

   assign core_reset = core_reset_reg;
   assign busy       = (state_reg == ST_LOAD) || (state_reg == ST_RUN);
   assign solved     = solved_reg;
   assign exhausted  = exhausted_reg;
   assign solved_key = solved_key_reg;
   assign keys_tried = keys_tried_reg;

endmodule
